uart_hex_tx: RTL and testbench

- Transmit side of the UART hex-display path: accepts one byte and sends it on the serial line as two ASCII hex characters, upper nibble first.
- Example: byte 0x3A is sent as '3' (0x33), then 'A' (0x41).
- Contains its own 8N1 bit serializer, so a terminal shows the same value the 7-segment digits display.
- Sits beside the UART receiver in the top level and is driven by the received-byte strobe or by a local source.

---
 rtl/uart_hex_pkg.sv | 25 ++
 rtl/uart_hex_tx_if.sv | 11 +
 rtl/uart_hex_tx_serializer.sv | 91 +++++++++
 rtl/uart_hex_tx.sv | 105 ++++++++++
 tb/tb_uart_hex_tx.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/uart_hex_pkg.sv
// Shared types, constants and helpers for the UART hex transmitter.
// Optional CR/LF trailer enabled by defining UART_HEX_TX_CRLF_EN.
package uart_hex_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} tx_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef UART_HEX_TX_CRLF_EN
    localparam int unsigned NUM_CHARS = 4;
`else
    localparam int unsigned NUM_CHARS = 2;
`endif

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/uart_hex_tx_if.sv
// Handshake and serial-line bundle for the UART hex transmitter.
interface uart_hex_tx_if;
    logic [7:0] tx_byte;
    logic       dv;
    logic       busy;
    logic       done;
    logic       serial;

    modport master (output tx_byte, output dv, input busy, input done, input serial);
    modport slave  (input tx_byte, input dv, output busy, output done, output serial);
endinterface

// File: rtl/uart_hex_tx_serializer.sv
// 8N1 bit serializer: one start bit, 8 data bits LSB first, one stop bit.
// A start strobe during the last stop-bit cycle chains the next character with no gap.
module uart_hex_tx_serializer
    import uart_hex_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] char_in,
    output logic       serial,
    output logic       char_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    tx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      char_q;
    logic            serial_q;
    logic            bit_end;
    logic            load;

    assign bit_end   = (cnt_q == CntMax);
    assign char_done = (state_q == STOP) && bit_end;
    assign load      = start && ((state_q == IDLE) || char_done);
    assign serial    = serial_q;

    // Bit timing and frame sequencing; line output is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            char_q    <= '0;
            serial_q  <= 1'b1;
        end else if (load) begin
            state_q   <= START;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            char_q    <= char_in;
            serial_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        cnt_q    <= '0;
                        state_q  <= DATA;
                        serial_q <= char_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q  <= STOP;
                            serial_q <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            serial_q  <= char_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                        serial_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    serial_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_hex_tx.sv
// UART hex transmitter: sends a byte as two ASCII hex characters, upper nibble first.
// Define UART_HEX_TX_CRLF_EN to append CR and LF after the hex pair.
module uart_hex_tx
    import uart_hex_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic          clk,
    input  logic          rst,
    uart_hex_tx_if.slave  bus
);

    localparam logic [1:0] LastIdx = 2'(NUM_CHARS - 1);

    // START is the one-cycle launch of the first character; DATA covers the whole message
    tx_state_e  state_q;
    logic [1:0] char_idx_q;
    logic [7:0] byte_q;
    logic       busy_q;
    logic       done_q;

    logic       ser_start;
    logic       ser_done;
    logic [1:0] next_idx;
    logic [7:0] char_sel;
    logic       last_char;

    assign last_char = (char_idx_q == LastIdx);
    assign ser_start = (state_q == START) || ((state_q == DATA) && ser_done && !last_char);
    assign next_idx  = (state_q == START) ? 2'd0 : char_idx_q + 2'd1;

    // Character to hand the serializer on its next start
    always_comb begin
        char_sel = nibble_to_ascii(byte_q[7:4]);
        case (next_idx)
            2'd1:    char_sel = nibble_to_ascii(byte_q[3:0]);
`ifdef UART_HEX_TX_CRLF_EN
            2'd2:    char_sel = ASCII_CR;
            2'd3:    char_sel = ASCII_LF;
`endif
            default: char_sel = nibble_to_ascii(byte_q[7:4]);
        endcase
    end

    // Message sequencing plus busy/done generation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            char_idx_q <= '0;
            byte_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.dv) begin
                        byte_q     <= bus.tx_byte;
                        char_idx_q <= '0;
                        state_q    <= START;
                    end
                end
                START: begin
                    busy_q  <= 1'b1;
                    state_q <= DATA;
                end
                DATA: begin
                    if (ser_done) begin
                        if (last_char) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            char_idx_q <= char_idx_q + 2'd1;
                        end
                    end
                end
                DONE: begin
                    done_q     <= 1'b0;
                    char_idx_q <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    uart_hex_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .start     (ser_start),
        .char_in   (char_sel),
        .serial    (bus.serial),
        .char_done (ser_done)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx with CLKS_PER_BIT=4.
module tb_uart_hex_tx;
    import uart_hex_pkg::*;

    localparam int unsigned Cpb = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    uart_hex_tx_if bus_if ();

    uart_hex_tx #(
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " line"}, 32'(bus_if.serial), 32'd1);
        check_eq({tag, " busy"}, 32'(bus_if.busy), 32'd0);
        check_eq({tag, " done"}, 32'(bus_if.done), 32'd0);
    endtask

    // Called just after a sampled edge. rej: pulse dv with other data while busy.
    // abort_cyc: assert reset after that cycle (0 = none). dv_done: strobe dv in the DONE cycle.
    task automatic send(input logic [7:0] b, input logic [7:0] c0, input logic [7:0] c1,
                        input bit rej, input int abort_cyc, input bit dv_done);
        logic [7:0] exp_c [4];
        logic       exp_bit;
        int         bit_no;
        int         ch;
        int         pos;
        int         total;
        exp_c[0] = c0;
        exp_c[1] = c1;
        exp_c[2] = 8'h0D;
        exp_c[3] = 8'h0A;
        total = int'(NUM_CHARS) * 10 * int'(Cpb);

        bus_if.tx_byte = b;
        bus_if.dv      = 1'b1;
        @(posedge clk);
        #1;
        bus_if.dv      = 1'b0;
        bus_if.tx_byte = ~b;
        check_eq($sformatf("accept-edge line %02h", b), 32'(bus_if.serial), 32'd1);

        for (int cyc = 1; cyc <= total; cyc++) begin
            @(posedge clk);
            #1;
            bit_no = (cyc - 1) / int'(Cpb);
            ch     = bit_no / 10;
            pos    = bit_no % 10;
            if (pos == 0) exp_bit = 1'b0;
            else if (pos == 9) exp_bit = 1'b1;
            else exp_bit = exp_c[ch][pos-1];
            check_eq($sformatf("line %02h c%0d", b, cyc), 32'(bus_if.serial), 32'(exp_bit));
            check_eq($sformatf("busy %02h c%0d", b, cyc), 32'(bus_if.busy), 32'd1);
            check_eq($sformatf("done %02h c%0d", b, cyc), 32'(bus_if.done), 32'd0);
            if (cyc == abort_cyc) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check_idle($sformatf("abort-edge %02h", b));
                for (int k = 0; k < 100; k++) begin
                    @(posedge clk);
                    #1;
                    check_idle($sformatf("post-abort %02h k%0d", b, k));
                end
                return;
            end
            if (rej) begin
                bus_if.tx_byte = 8'hAB;
                bus_if.dv      = (cyc == 9) || (cyc == 39);
            end
        end
        bus_if.dv = 1'b0;

        @(posedge clk);
        #1;
        check_eq($sformatf("done-pulse %02h", b), 32'(bus_if.done), 32'd1);
        check_eq($sformatf("done-busy %02h", b), 32'(bus_if.busy), 32'd0);
        check_eq($sformatf("done-line %02h", b), 32'(bus_if.serial), 32'd1);
        if (dv_done) bus_if.dv = 1'b1;
        @(posedge clk);
        #1;
        bus_if.dv = 1'b0;
        check_idle($sformatf("after-done %02h", b));
        @(posedge clk);
        #1;
        check_idle($sformatf("idle2 %02h", b));
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus_if.dv      = 1'b0;
        bus_if.tx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle("in-reset");
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            check_idle($sformatf("reset-idle k%0d", k));
        end

        send(8'h3A, 8'h33, 8'h41, 1'b0, 0, 1'b0);
        send(8'h09, 8'h30, 8'h39, 1'b0, 0, 1'b1);
        send(8'hF0, 8'h46, 8'h30, 1'b0, 0, 1'b0);
        send(8'h00, 8'h30, 8'h30, 1'b0, 0, 1'b0);
        send(8'hFF, 8'h46, 8'h46, 1'b0, 0, 1'b0);
        send(8'h12, 8'h31, 8'h32, 1'b1, 0, 1'b0);
        // Reset lands in the data bits of the second character
        send(8'h3A, 8'h33, 8'h41, 1'b0, 50, 1'b0);
        send(8'h55, 8'h35, 8'h35, 1'b0, 0, 1'b0);
        send(8'hC3, 8'h43, 8'h33, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
